// File: rtl/div_iter.sv
// div_iter: radix-2 restoring divider for DIV/DIVU in EX.
// Holds the pipeline while iterating; quotient -> LO, remainder -> HI.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             sign_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             annul,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

  state_t state, nstate;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvsr;
  logic [WIDTH-1:0] q_reg, r_reg;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, trial;
  logic             qsign, rsign, dz;
  logic             accept, dz_in;

  assign accept = (state == IDLE) & start & ~annul;
  assign dz_in  = (divisor == '0);

  assign a_mag = (sign_div & dividend[WIDTH-1]) ? -dividend : dividend;
  assign b_mag = (sign_div & divisor[WIDTH-1])  ? -divisor  : divisor;

  // Borrow out of the WIDTH+1 bit subtract decides the quotient bit.
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvsr};

  // Divide-by-zero keeps the raw dividend in rem and skips sign fix.
  assign q_fix = dz ? '1 : (qsign ? -quo : quo);
  assign r_fix = dz ? rem : (rsign ? -rem : rem);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nstate;
  end

  // Next-state logic; annul always returns to IDLE.
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (accept) nstate = dz_in ? FINISH : CALC;
      end
      CALC: begin
        if (annul)              nstate = IDLE;
        else if (cnt == CW'(1)) nstate = FINISH;
      end
      FINISH: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Outputs: results shown live in the done cycle, held otherwise.
  always_comb begin
    stall     = accept | (state == CALC);
    done      = (state == FINISH) & ~annul;
    quotient  = done ? q_fix : q_reg;
    remainder = done ? r_fix : r_reg;
  end

  // Operand capture, shift/subtract iteration and result hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      qsign <= 1'b0;
      rsign <= 1'b0;
      dz    <= 1'b0;
      q_reg <= '0;
      r_reg <= '0;
    end else begin
      if (accept) begin
        dvsr  <= b_mag;
        quo   <= a_mag;
        rem   <= dz_in ? dividend : '0;
        cnt   <= CW'(WIDTH);
        qsign <= (dividend[WIDTH-1] ^ divisor[WIDTH-1]) & sign_div;
        rsign <= dividend[WIDTH-1] & sign_div;
        dz    <= dz_in;
      end else if (state == CALC) begin
        cnt <= cnt - 1'b1;
        quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
        rem <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
      end
      if (done) begin
        q_reg <= q_fix;
        r_reg <= r_fix;
      end
    end
  end

endmodule
